// File: rtl/v_lanes_pkg.sv
// Shared encodings, FSM state type and defaults for the vector lane dispatcher.
package v_lanes_pkg;

    localparam int unsigned VlenDefault = 128;

    localparam logic [2:0] Lmul1 = 3'b000;
    localparam logic [2:0] Lmul2 = 3'b001;
    localparam logic [2:0] Lmul4 = 3'b010;

    localparam logic [1:0] Lanes4  = 2'b00;
    localparam logic [1:0] Lanes8  = 2'b01;
    localparam logic [1:0] Lanes16 = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRead,
        StIssue,
        StWait,
        StCmpl
    } disp_state_e;

    // Group size in registers; illegal codes map to 4 and are rejected separately.
    function automatic logic [2:0] nregs_of(input logic [2:0] lmul);
        case (lmul)
            Lmul1:   return 3'd1;
            Lmul2:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic lmul_legal(input logic [2:0] lmul);
        return lmul inside {Lmul1, Lmul2, Lmul4};
    endfunction

    function automatic logic lanes_legal(input logic [1:0] lanes);
        return lanes inside {Lanes4, Lanes8, Lanes16};
    endfunction

endpackage

// File: rtl/v_operand_stage.sv
// Eight VLEN-wide operand chunk registers (four per source) written one slot per beat.
module v_operand_stage
    import v_lanes_pkg::*;
#(
    parameter int unsigned VLEN = VlenDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr,
    input  logic [1:0]           slot,
    input  logic [VLEN-1:0]      data_a,
    input  logic [VLEN-1:0]      data_b,
    output logic [3:0][VLEN-1:0] op_a,
    output logic [3:0][VLEN-1:0] op_b
);

    // Clear has priority so a new request never inherits a stale chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (clr) begin
            op_a <= '0;
            op_b <= '0;
        end else if (wr) begin
            op_a[slot] <= data_a;
            op_b[slot] <= data_b;
        end
    end

endmodule

// File: rtl/v_lane_dispatch.sv
// Issue-side initiator: reads vs1/vs2 groups, stages operands, starts lanes, reports completion.
// Optional lane watchdog enabled by defining V_DISPATCH_TIMEOUT_EN.
module v_lane_dispatch
    import v_lanes_pkg::*;
#(
    parameter int unsigned VLEN           = VlenDefault,
    parameter int unsigned NREG           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [5:0]              req_op_alu,
    input  logic [5:0]              req_op_mul,
    input  logic [2:0]              req_vsew,
    input  logic [2:0]              req_lmul,
    input  logic [1:0]              req_lanes,
    input  logic [$clog2(NREG)-1:0] req_vs1,
    input  logic [$clog2(NREG)-1:0] req_vs2,
    output logic                    rf_rd_en,
    output logic [$clog2(NREG)-1:0] rf_addr_a,
    output logic [$clog2(NREG)-1:0] rf_addr_b,
    input  logic [VLEN-1:0]         rf_data_a,
    input  logic [VLEN-1:0]         rf_data_b,
    output logic [5:0]              op_instr_alu,
    output logic [5:0]              op_instr_mul,
    output logic [2:0]              vsew,
    output logic [2:0]              lmul,
    output logic [1:0]              lanes,
    output logic [VLEN-1:0]         op_A_1,
    output logic [VLEN-1:0]         op_A_2,
    output logic [VLEN-1:0]         op_A_3,
    output logic [VLEN-1:0]         op_A_4,
    output logic [VLEN-1:0]         op_B_1,
    output logic [VLEN-1:0]         op_B_2,
    output logic [VLEN-1:0]         op_B_3,
    output logic [VLEN-1:0]         op_B_4,
    output logic                    lane_start,
    input  logic                    lane_done,
    output logic                    cmpl_valid,
    output logic                    cmpl_err
);

    localparam int unsigned AW = $clog2(NREG);

    disp_state_e          state;
    logic [2:0]           k;
    logic [2:0]           k_next;
    logic [AW-1:0]        vs1_q;
    logic [AW-1:0]        vs2_q;
    logic [2:0]           nregs;
    logic [AW-1:0]        align_mask;
    logic                 legal;
    logic                 accept;
    logic                 stage_wr;
    logic [1:0]           stage_slot;
    logic [3:0][VLEN-1:0] op_a;
    logic [3:0][VLEN-1:0] op_b;

`ifdef V_DISPATCH_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wd_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign req_ready = (state == StIdle);
    assign accept    = req_valid && (state == StIdle);
    assign k_next    = k + 3'd1;

    always_comb begin
        nregs      = nregs_of(lmul);
        align_mask = AW'(nregs - 3'd1);
        legal      = lmul_legal(lmul) && lanes_legal(lanes) &&
                     ((vs1_q & align_mask) == '0) && ((vs2_q & align_mask) == '0);
    end

    // Beat k (k >= 1) captures the data of the read issued in the previous cycle.
    assign stage_wr   = (state == StRead) && (k != 3'd0);
    assign stage_slot = 2'(k - 3'd1);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state        <= StIdle;
            k            <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            op_instr_alu <= '0;
            op_instr_mul <= '0;
            vsew         <= '0;
            lmul         <= '0;
            lanes        <= '0;
            rf_rd_en     <= 1'b0;
            rf_addr_a    <= '0;
            rf_addr_b    <= '0;
            lane_start   <= 1'b0;
            cmpl_valid   <= 1'b0;
            cmpl_err     <= 1'b0;
`ifdef V_DISPATCH_TIMEOUT_EN
            wd_cnt       <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        op_instr_alu <= req_op_alu;
                        op_instr_mul <= req_op_mul;
                        vsew         <= req_vsew;
                        lmul         <= req_lmul;
                        lanes        <= req_lanes;
                        vs1_q        <= req_vs1;
                        vs2_q        <= req_vs2;
                        state        <= StCheck;
                    end
                end
                StCheck: begin
                    if (legal) begin
                        k         <= '0;
                        rf_rd_en  <= 1'b1;
                        rf_addr_a <= vs1_q;
                        rf_addr_b <= vs2_q;
                        state     <= StRead;
                    end else begin
                        cmpl_valid <= 1'b1;
                        cmpl_err   <= 1'b1;
                        state      <= StCmpl;
                    end
                end
                StRead: begin
                    k <= k_next;
                    if (k_next < nregs) begin
                        rf_rd_en  <= 1'b1;
                        rf_addr_a <= vs1_q + AW'(k_next);
                        rf_addr_b <= vs2_q + AW'(k_next);
                    end else begin
                        rf_rd_en <= 1'b0;
                    end
                    if (k == nregs) begin
                        lane_start <= 1'b1;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    lane_start <= 1'b0;
`ifdef V_DISPATCH_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                    state      <= StWait;
                end
                StWait: begin
                    if (lane_done) begin
                        cmpl_valid <= 1'b1;
                        cmpl_err   <= 1'b0;
                        state      <= StCmpl;
                    end
`ifdef V_DISPATCH_TIMEOUT_EN
                    else if (wd_cnt == WdW'(TIMEOUT_CYCLES)) begin
                        cmpl_valid <= 1'b1;
                        cmpl_err   <= 1'b1;
                        state      <= StCmpl;
                    end else begin
                        wd_cnt <= wd_cnt + WdW'(1);
                    end
`endif
                end
                StCmpl: begin
                    cmpl_valid <= 1'b0;
                    cmpl_err   <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    v_operand_stage #(
        .VLEN (VLEN)
    ) u_stage (
        .clk    (clk),
        .rst    (nrst),
        .clr    (accept),
        .wr     (stage_wr),
        .slot   (stage_slot),
        .data_a (rf_data_a),
        .data_b (rf_data_b),
        .op_a   (op_a),
        .op_b   (op_b)
    );

    assign op_A_1 = op_a[0];
    assign op_A_2 = op_a[1];
    assign op_A_3 = op_a[2];
    assign op_A_4 = op_a[3];
    assign op_B_1 = op_b[0];
    assign op_B_2 = op_b[1];
    assign op_B_3 = op_b[2];
    assign op_B_4 = op_b[3];

endmodule

// File: tb/tb_v_lane_dispatch.sv
// Scoreboard bench for v_lane_dispatch: directed requests, decoupled completion monitor.
module tb_v_lane_dispatch;

    localparam int VLEN = 128;

    logic            clk = 1'b0;
    logic            nrst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [5:0]      req_op_alu = '0;
    logic [5:0]      req_op_mul = '0;
    logic [2:0]      req_vsew = '0;
    logic [2:0]      req_lmul = '0;
    logic [1:0]      req_lanes = '0;
    logic [4:0]      req_vs1 = '0;
    logic [4:0]      req_vs2 = '0;
    logic            rf_rd_en;
    logic [4:0]      rf_addr_a;
    logic [4:0]      rf_addr_b;
    logic [VLEN-1:0] rf_data_a = '0;
    logic [VLEN-1:0] rf_data_b = '0;
    logic [5:0]      op_instr_alu;
    logic [5:0]      op_instr_mul;
    logic [2:0]      vsew;
    logic [2:0]      lmul;
    logic [1:0]      lanes;
    logic [VLEN-1:0] op_A_1, op_A_2, op_A_3, op_A_4;
    logic [VLEN-1:0] op_B_1, op_B_2, op_B_3, op_B_4;
    logic            lane_start;
    logic            lane_done = 1'b0;
    logic            cmpl_valid;
    logic            cmpl_err;

    v_lane_dispatch dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op_alu   (req_op_alu),
        .req_op_mul   (req_op_mul),
        .req_vsew     (req_vsew),
        .req_lmul     (req_lmul),
        .req_lanes    (req_lanes),
        .req_vs1      (req_vs1),
        .req_vs2      (req_vs2),
        .rf_rd_en     (rf_rd_en),
        .rf_addr_a    (rf_addr_a),
        .rf_addr_b    (rf_addr_b),
        .rf_data_a    (rf_data_a),
        .rf_data_b    (rf_data_b),
        .op_instr_alu (op_instr_alu),
        .op_instr_mul (op_instr_mul),
        .vsew         (vsew),
        .lmul         (lmul),
        .lanes        (lanes),
        .op_A_1       (op_A_1),
        .op_A_2       (op_A_2),
        .op_A_3       (op_A_3),
        .op_A_4       (op_A_4),
        .op_B_1       (op_B_1),
        .op_B_2       (op_B_2),
        .op_B_3       (op_B_3),
        .op_B_4       (op_B_4),
        .lane_start   (lane_start),
        .lane_done    (lane_done),
        .cmpl_valid   (cmpl_valid),
        .cmpl_err     (cmpl_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Register file model: 0 = fixed A/B patterns, 1 = data equals address.
    logic            rf_mode = 1'b0;
    logic [VLEN-1:0] pat_a;
    logic [VLEN-1:0] pat_b;
    assign pat_a = {32{4'hA}};
    assign pat_b = {32{4'hB}};

    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_data_a <= rf_mode ? VLEN'(rf_addr_a) : pat_a;
            rf_data_b <= rf_mode ? VLEN'(rf_addr_b) : pat_b;
        end
    end

    typedef struct {
        logic err;
        int   cyc;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [4:0] a;
        logic [4:0] b;
    } rd_t;

    exp_t sb[$];
    rd_t  rd_log[$];
    int   start_cnt = 0;
    int   start_cyc = 0;

    // Monitor: log reads and starts, pop the scoreboard on every completion.
    always @(negedge clk) begin
        exp_t e;
        rd_t  r;
        if (rf_rd_en) begin
            r.cyc = cyc;
            r.a   = rf_addr_a;
            r.b   = rf_addr_b;
            rd_log.push_back(r);
        end
        if (lane_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (cmpl_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_cmpl", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("cmpl_err", cmpl_err, e.err);
                check("cmpl_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready_wait"}, req_ready, 1'b1);
    endtask

    task automatic run_req(input string tag, input logic [2:0] lm, input logic [1:0] ln,
                           input logic [4:0] v1, input logic [4:0] v2, input int done_rel,
                           input int early_rel, input logic exp_err);
        int   t0, nr, last;
        exp_t e;
        wait_ready(tag);
        rd_log.delete();
        start_cnt = 0;
        nr = (lm == 3'd0) ? 1 : (lm == 3'd1) ? 2 : 4;
        t0 = cyc;
        req_lmul  = lm;
        req_lanes = ln;
        req_vs1   = v1;
        req_vs2   = v2;
        req_valid = 1'b1;
        e.err = exp_err;
        e.cyc = exp_err ? t0 + 2 : t0 + done_rel + 1;
        sb.push_back(e);
        last = exp_err ? 3 : done_rel + 2;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lane_done = (!exp_err && c == done_rel) || (early_rel != 0 && c == early_rel);
            if (c == 1) check({tag, "_busy"}, req_ready, 1'b0);
        end
        lane_done = 1'b0;
        check({tag, "_ready_back"}, req_ready, 1'b1);
        check({tag, "_sb_drained"}, sb.size(), 0);
        if (exp_err) begin
            check({tag, "_no_reads"}, rd_log.size(), 0);
            check({tag, "_no_start"}, start_cnt, 0);
        end else begin
            check({tag, "_read_count"}, rd_log.size(), nr);
            for (int i = 0; i < nr && i < rd_log.size(); i++) begin
                check({tag, "_read_cycle"}, rd_log[i].cyc, t0 + 2 + i);
                check({tag, "_read_addr_a"}, rd_log[i].a, v1 + 5'(i));
                check({tag, "_read_addr_b"}, rd_log[i].b, v2 + 5'(i));
            end
            check({tag, "_start_count"}, start_cnt, 1);
            check({tag, "_start_cycle"}, start_cyc, t0 + nr + 3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_rd_en", rf_rd_en, 1'b0);
        check("rst_start", lane_start, 1'b0);
        check("rst_cmpl", cmpl_valid, 1'b0);
        check("rst_op_a1", op_A_1, '0);
        nrst = 1'b0;
        @(negedge clk);

        // LMUL=1: single read at 3/5, start at 4, done at 7, completion at 8.
        req_op_alu = 6'h15;
        req_op_mul = 6'h2A;
        req_vsew   = 3'b010;
        rf_mode    = 1'b0;
        run_req("t1", 3'b000, 2'b00, 5'd3, 5'd5, 7, 0, 1'b0);
        check("t1_op_a1", op_A_1, pat_a);
        check("t1_op_b1", op_B_1, pat_b);
        check("t1_op_a2", op_A_2, '0);
        check("t1_op_a4", op_A_4, '0);
        check("t1_op_b4", op_B_4, '0);
        check("t1_alu", op_instr_alu, 6'h15);
        check("t1_mul", op_instr_mul, 6'h2A);
        check("t1_vsew", vsew, 3'b010);
        check("t1_lmul", lmul, 3'b000);

        // LMUL=4: four reads, data equals address.
        rf_mode = 1'b1;
        run_req("t2", 3'b010, 2'b10, 5'd8, 5'd12, 8, 0, 1'b0);
        check("t2_op_a1", op_A_1, 128'd8);
        check("t2_op_a2", op_A_2, 128'd9);
        check("t2_op_a3", op_A_3, 128'd10);
        check("t2_op_a4", op_A_4, 128'd11);
        check("t2_op_b1", op_B_1, 128'd12);
        check("t2_op_b4", op_B_4, 128'd15);
        check("t2_lanes", lanes, 2'b10);

        // LMUL=2 with a lane_done pulse during READ that must be ignored.
        run_req("t3", 3'b001, 2'b01, 5'd2, 5'd6, 6, 3, 1'b0);
        check("t3_op_a1", op_A_1, 128'd2);
        check("t3_op_a2", op_A_2, 128'd3);
        check("t3_op_a3", op_A_3, '0);
        check("t3_op_b2", op_B_2, 128'd7);

        // LMUL=1 after LMUL=2: upper chunks must be cleared on accept.
        run_req("t4", 3'b000, 2'b00, 5'd31, 5'd0, 9, 0, 1'b0);
        check("t4_op_a1", op_A_1, 128'd31);
        check("t4_op_a2", op_A_2, '0);
        check("t4_op_b2", op_B_2, '0);

        // Illegal requests: misaligned vs1, lmul=011, lanes=11, misaligned vs2.
        run_req("t5", 3'b001, 2'b00, 5'd3, 5'd4, 0, 0, 1'b1);
        check("t5_op_a1", op_A_1, '0);
        run_req("t6", 3'b011, 2'b00, 5'd0, 5'd0, 0, 0, 1'b1);
        run_req("t7", 3'b000, 2'b11, 5'd0, 5'd0, 0, 0, 1'b1);
        run_req("t8", 3'b010, 2'b00, 5'd0, 5'd6, 0, 0, 1'b1);

        // Reset in the middle of READ: request dropped, no completion.
        wait_ready("t9");
        start_cnt = 0;
        req_lmul  = 3'b010;
        req_lanes = 2'b00;
        req_vs1   = 5'd16;
        req_vs2   = 5'd20;
        req_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < t0 + 4) @(negedge clk);
        check("t9_pre_rd_en", rf_rd_en, 1'b1);
        check("t9_pre_op_a1", op_A_1, 128'd16);
        nrst = 1'b1;
        #1;
        check("t9_ready", req_ready, 1'b1);
        check("t9_rd_en", rf_rd_en, 1'b0);
        check("t9_op_a1", op_A_1, '0);
        check("t9_op_b1", op_B_1, '0);
        check("t9_lmul", lmul, 3'b000);
        @(negedge clk);
        nrst = 1'b0;
        repeat (12) @(negedge clk);
        check("t9_no_start", start_cnt, 0);
        check("t9_sb_empty", sb.size(), 0);

        // Recovery after reset.
        run_req("t10", 3'b001, 2'b00, 5'd4, 5'd10, 7, 0, 1'b0);
        check("t10_op_a2", op_A_2, 128'd5);
        check("t10_op_b1", op_B_1, 128'd10);

        repeat (3) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
